// File: rtl/cv32e41s_pkg.sv
// Shared types for the cv32e41s CLIC arbiter slice.
// Source configuration record, privilege encoding and level width.
package cv32e41s_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  localparam int CLIC_LEVEL_W = 8;

  typedef struct packed {
    logic                    ie;
    logic                    shv;
    logic                    edge_trig;
    logic [CLIC_LEVEL_W-1:0] level;
  } clic_src_cfg_t;

  function automatic logic clic_cand(
    input clic_src_cfg_t c,
    input logic          p
  );
    return p & c.ie & (c.level != '0);
  endfunction

endpackage

// File: rtl/cv32e41s_clic_max_select.sv
// Comparator tree picking the highest-level valid entry.
// Ties go to the higher ID; with no valid entry the result is all zero.
module cv32e41s_clic_max_select
  import cv32e41s_pkg::*;
#(
  parameter int NUM  = 32,
  parameter int ID_W = 5
) (
  input  logic [NUM-1:0]                   valid,
  input  logic [NUM-1:0][CLIC_LEVEL_W-1:0] level,
  input  logic [NUM-1:0]                   shv,
  output logic                             win_valid,
  output logic [ID_W-1:0]                  win_id,
  output logic [CLIC_LEVEL_W-1:0]          win_level,
  output logic                             win_shv
);

  localparam int LEAVES = 1 << ID_W;

  typedef struct packed {
    logic                    valid;
    logic [ID_W-1:0]         id;
    logic [CLIC_LEVEL_W-1:0] level;
    logic                    shv;
  } node_t;

  node_t node [1:2*LEAVES-1];

  // Right child holds the higher IDs, so it wins ties.
  function automatic node_t pick(input node_t l, input node_t r);
    if (r.valid && (!l.valid || r.level >= l.level))
      return r;
    return l;
  endfunction

  always_comb begin
    for (int k = 1; k < 2*LEAVES; k++)
      node[k] = '0;
    for (int i = 0; i < NUM; i++) begin
      if (valid[i]) begin
        node[LEAVES+i].valid = 1'b1;
        node[LEAVES+i].id    = ID_W'(i);
        node[LEAVES+i].level = level[i];
        node[LEAVES+i].shv   = shv[i];
      end
    end
    for (int k = LEAVES-1; k >= 1; k--)
      node[k] = pick(node[2*k], node[2*k+1]);
  end

  assign win_valid = node[1].valid;
  assign win_id    = node[1].id;
  assign win_level = node[1].level;
  assign win_shv   = node[1].shv;

endmodule

// File: rtl/cv32e41s_clic_arbiter.sv
// CLIC arbiter: pending latch, max-select and registered core-facing
// interrupt presentation with post-acknowledge blanking.
module cv32e41s_clic_arbiter
  import cv32e41s_pkg::*;
#(
  parameter int NUM_IRQ       = 32,
  parameter int CLIC_ID_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IRQ-1:0]       irq_i,
  input  logic                     cfg_we_i,
  input  logic [CLIC_ID_WIDTH-1:0] cfg_id_i,
  input  logic                     cfg_ie_i,
  input  logic [7:0]               cfg_level_i,
  input  logic                     cfg_shv_i,
  input  logic                     cfg_edge_i,
  input  logic                     irq_ack_i,
  input  logic [CLIC_ID_WIDTH-1:0] irq_ack_id_i,
  output logic                     clic_irq_o,
  output logic [CLIC_ID_WIDTH-1:0] clic_irq_id_o,
  output logic [7:0]               clic_irq_level_o,
  output logic [1:0]               clic_irq_priv_o,
  output logic                     clic_irq_shv_o,
  output logic [NUM_IRQ-1:0]       ip_o
);

  clic_src_cfg_t cfg [NUM_IRQ];

  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] ip_nxt;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] shv_v;
  logic [NUM_IRQ-1:0][CLIC_LEVEL_W-1:0] lvl_v;

  logic                     sel_valid;
  logic [CLIC_ID_WIDTH-1:0] sel_id;
  logic [CLIC_LEVEL_W-1:0]  sel_level;
  logic                     sel_shv;

  logic                     s2_valid;
  logic [CLIC_ID_WIDTH-1:0] s2_id;
  logic [CLIC_LEVEL_W-1:0]  s2_level;
  logic                     s2_shv;
  logic [1:0]               blank_cnt;

  always_comb begin
    ip_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cfg[i].edge_trig)
        ip_nxt[i] = (irq_i[i] & ~irq_q[i]) |
                    (ip[i] & ~(irq_ack_i &&
                     irq_ack_id_i == CLIC_ID_WIDTH'(i)));
      else
        ip_nxt[i] = irq_i[i];
      // Switching trigger type discards stale pending state.
      if (cfg_we_i && cfg_id_i == CLIC_ID_WIDTH'(i) &&
          cfg_edge_i != cfg[i].edge_trig)
        ip_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    cand  = '0;
    lvl_v = '0;
    shv_v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      cand[i]  = clic_cand(cfg[i], ip[i]);
      lvl_v[i] = cfg[i].level;
      shv_v[i] = cfg[i].shv;
    end
  end

  cv32e41s_clic_max_select #(
    .NUM  (NUM_IRQ),
    .ID_W (CLIC_ID_WIDTH)
  ) u_sel (
    .valid     (cand),
    .level     (lvl_v),
    .shv       (shv_v),
    .win_valid (sel_valid),
    .win_id    (sel_id),
    .win_level (sel_level),
    .win_shv   (sel_shv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ip        <= '0;
      irq_q     <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_level  <= '0;
      s2_shv    <= 1'b0;
      blank_cnt <= '0;
      for (int i = 0; i < NUM_IRQ; i++)
        cfg[i] <= '0;
    end else begin
      ip       <= ip_nxt;
      irq_q    <= irq_i;
      s2_valid <= sel_valid;
      s2_id    <= sel_id;
      s2_level <= sel_level;
      s2_shv   <= sel_shv;
      if (irq_ack_i)
        blank_cnt <= 2'd2;
      else if (blank_cnt != '0)
        blank_cnt <= blank_cnt - 2'd1;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cfg_we_i && cfg_id_i == CLIC_ID_WIDTH'(i)) begin
          cfg[i].ie        <= cfg_ie_i;
          cfg[i].shv       <= cfg_shv_i;
          cfg[i].edge_trig <= cfg_edge_i;
          cfg[i].level     <= cfg_level_i;
        end
      end
    end
  end

  assign clic_irq_o       = s2_valid & (blank_cnt == '0);
  assign clic_irq_id_o    = s2_id;
  assign clic_irq_level_o = s2_level;
  assign clic_irq_shv_o   = s2_shv;
  assign clic_irq_priv_o  = PRIV_LVL_M;
  assign ip_o             = ip;

endmodule

// File: tb/tb_cv32e41s_clic_arbiter.sv
// Bench for cv32e41s_clic_arbiter: directed vector table plus
// randomized traffic against a source-level reference model.
module tb_cv32e41s_clic_arbiter;
  import cv32e41s_pkg::*;

  localparam int N  = 24;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  irq;
  logic          we;
  logic [IW-1:0] cid;
  logic          ie;
  logic [7:0]    lvl;
  logic          shv;
  logic          edg;
  logic          ack;
  logic [IW-1:0] aid;
  logic          o_irq;
  logic [IW-1:0] o_id;
  logic [7:0]    o_lvl;
  logic [1:0]    o_priv;
  logic          o_shv;
  logic [N-1:0]  o_ip;

  cv32e41s_clic_arbiter #(
    .NUM_IRQ       (N),
    .CLIC_ID_WIDTH (IW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .irq_i            (irq),
    .cfg_we_i         (we),
    .cfg_id_i         (cid),
    .cfg_ie_i         (ie),
    .cfg_level_i      (lvl),
    .cfg_shv_i        (shv),
    .cfg_edge_i       (edg),
    .irq_ack_i        (ack),
    .irq_ack_id_i     (aid),
    .clic_irq_o       (o_irq),
    .clic_irq_id_o    (o_id),
    .clic_irq_level_o (o_lvl),
    .clic_irq_priv_o  (o_priv),
    .clic_irq_shv_o   (o_shv),
    .ip_o             (o_ip)
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  irq;
    logic          we;
    logic [IW-1:0] cid;
    logic          ie;
    logic [7:0]    lvl;
    logic          shv;
    logic          edg;
    logic          ack;
    logic [IW-1:0] aid;
    logic          chk;
    logic          eirq;
    logic [IW-1:0] eid;
    logic [7:0]    elvl;
    logic          chkip;
    logic [N-1:0]  eip;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_mis = 0;

  bit m_ip   [N];
  bit m_ie   [N];
  int m_lvl  [N];
  bit m_shv  [N];
  bit m_edge [N];
  bit m_irqq [N];
  bit m_s2v;
  int m_s2id;
  int m_s2lvl;
  bit m_s2shv;
  int m_since;

  function automatic logic [N-1:0] b(input int k);
    logic [N-1:0] one;
    one = 1;
    return one << k;
  endfunction

  function automatic vec_t nv(input logic [N-1:0] i, input logic ei,
                              input int id, input int lv);
    vec_t x;
    x.rst = 0; x.irq = i; x.we = 0; x.cid = '0;
    x.ie = 0; x.lvl = '0; x.shv = 0; x.edg = 0;
    x.ack = 0; x.aid = '0; x.chk = 1; x.eirq = ei;
    x.eid = IW'(id); x.elvl = 8'(lv); x.chkip = 0; x.eip = '0;
    return x;
  endfunction

  function automatic vec_t cv(input int c, input logic e, input int l,
                              input logic s, input logic ed,
                              input logic ei, input int id, input int lv);
    vec_t x;
    x = nv('0, ei, id, lv);
    x.we = 1; x.cid = IW'(c); x.ie = e;
    x.lvl = 8'(l); x.shv = s; x.edg = ed;
    return x;
  endfunction

  function automatic vec_t av(input logic [N-1:0] i, input int a,
                              input logic ei, input int id, input int lv);
    vec_t x;
    x = nv(i, ei, id, lv);
    x.ack = 1; x.aid = IW'(a);
    return x;
  endfunction

  function automatic vec_t ipc(input vec_t v, input logic [N-1:0] e);
    vec_t x;
    x = v; x.chkip = 1; x.eip = e;
    return x;
  endfunction

  task automatic model_step();
    bit bv; int bid; int bl; bit bs; bit rise; bit hit;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_ip[i] = 0; m_ie[i] = 0; m_lvl[i] = 0;
        m_shv[i] = 0; m_edge[i] = 0; m_irqq[i] = 0;
      end
      m_s2v = 0; m_s2id = 0; m_s2lvl = 0; m_s2shv = 0;
      m_since = 100;
    end else begin
      bv = 0; bid = 0; bl = 0; bs = 0;
      for (int i = 0; i < N; i++)
        if (m_ip[i] && m_ie[i] && m_lvl[i] != 0 && (!bv || m_lvl[i] >= bl)) begin
          bv = 1; bid = i; bl = m_lvl[i]; bs = m_shv[i];
        end
      for (int i = 0; i < N; i++) begin
        rise = irq[i] && !m_irqq[i];
        hit  = ack && int'(aid) == i;
        if (m_edge[i]) m_ip[i] = rise || (m_ip[i] && !hit);
        else m_ip[i] = irq[i];
        if (we && int'(cid) == i) begin
          if (edg != m_edge[i]) m_ip[i] = 0;
          m_ie[i] = ie; m_lvl[i] = int'(lvl);
          m_shv[i] = shv; m_edge[i] = edg;
        end
        m_irqq[i] = irq[i];
      end
      m_s2v = bv; m_s2id = bid; m_s2lvl = bl; m_s2shv = bs;
      m_since = ack ? 0 : (m_since < 100 ? m_since + 1 : 100);
    end
  endtask

  task automatic check(input vec_t x);
    logic [N-1:0] mip;
    logic eirq;
    n_vec++;
    for (int i = 0; i < N; i++) mip[i] = m_ip[i];
    eirq = m_s2v && m_since >= 2;
    if (o_irq !== eirq || o_id !== IW'(m_s2id) || o_lvl !== 8'(m_s2lvl) ||
        o_shv !== m_s2shv || o_priv !== 2'b11 || o_ip !== mip) begin
      $display("FAIL model vec %0d: got irq=%0b id=%0d lvl=%0h shv=%0b priv=%0b ip=%0h, required irq=%0b id=%0d lvl=%0h shv=%0b priv=11 ip=%0h",
               n_vec-1, o_irq, o_id, o_lvl, o_shv, o_priv, o_ip,
               eirq, m_s2id, m_s2lvl, m_s2shv, mip);
      n_mis++;
    end
    if (x.chk && (o_irq !== x.eirq || o_id !== x.eid || o_lvl !== x.elvl)) begin
      $display("FAIL table vec %0d: got irq=%0b id=%0d lvl=%0h, required irq=%0b id=%0d lvl=%0h",
               n_vec-1, o_irq, o_id, o_lvl, x.eirq, x.eid, x.elvl);
      n_mis++;
    end
    if (x.chkip && o_ip !== x.eip) begin
      $display("FAIL ip vec %0d: got %0h, required %0h", n_vec-1, o_ip, x.eip);
      n_mis++;
    end
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; irq = x.irq; we = x.we; cid = x.cid;
    ie = x.ie; lvl = x.lvl; shv = x.shv; edg = x.edg;
    ack = x.ack; aid = x.aid;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(x);
  endtask

  initial begin
    vec_t x;
    logic [N-1:0] cur;
    logic [N-1:0] p4;
    p4 = b(4) | b(6) | b(8) | b(10);

    x = nv('0, 0, 0, 0); x.rst = 1; tbl.push_back(ipc(x, '0));
    tbl.push_back(cv(3, 1, 'h40, 0, 1, 0, 0, 0));
    tbl.push_back(nv(b(3), 0, 0, 0));
    tbl.push_back(nv('0, 1, 3, 'h40));
    tbl.push_back(ipc(nv('0, 1, 3, 'h40), b(3)));
    tbl.push_back(av('0, 3, 0, 3, 'h40));
    tbl.push_back(ipc(nv('0, 0, 0, 0), '0));
    tbl.push_back(cv(5, 1, 'h20, 0, 1, 0, 0, 0));
    tbl.push_back(cv(9, 1, 'h80, 1, 1, 0, 0, 0));
    tbl.push_back(nv(b(5) | b(9), 0, 0, 0));
    tbl.push_back(nv('0, 1, 9, 'h80));
    tbl.push_back(cv(5, 1, 'h80, 0, 1, 1, 9, 'h80));
    tbl.push_back(nv('0, 1, 9, 'h80));
    tbl.push_back(cv(5, 1, 'h90, 0, 1, 1, 9, 'h80));
    tbl.push_back(nv('0, 1, 5, 'h90));
    tbl.push_back(cv(5, 1, 'h20, 0, 1, 1, 5, 'h90));
    tbl.push_back(nv('0, 1, 9, 'h80));
    tbl.push_back(av('0, 9, 0, 9, 'h80));
    tbl.push_back(nv('0, 0, 5, 'h20));
    tbl.push_back(ipc(nv('0, 1, 5, 'h20), b(5)));
    tbl.push_back(av('0, 5, 0, 5, 'h20));
    tbl.push_back(nv('0, 0, 0, 0));
    tbl.push_back(nv('0, 0, 0, 0));
    tbl.push_back(cv(7, 1, 'h10, 0, 0, 0, 0, 0));
    tbl.push_back(nv(b(7), 0, 0, 0));
    tbl.push_back(nv(b(7), 1, 7, 'h10));
    tbl.push_back(av(b(7), 7, 0, 7, 'h10));
    tbl.push_back(nv(b(7), 0, 7, 'h10));
    tbl.push_back(nv(b(7), 1, 7, 'h10));
    tbl.push_back(nv('0, 1, 7, 'h10));
    tbl.push_back(nv('0, 0, 0, 0));
    tbl.push_back(cv(11, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(cv(12, 0, 'h50, 0, 0, 0, 0, 0));
    tbl.push_back(nv(b(11) | b(12), 0, 0, 0));
    tbl.push_back(ipc(nv(b(11) | b(12), 0, 0, 0), b(11) | b(12)));
    tbl.push_back(cv(24, 1, 'hff, 1, 1, 0, 0, 0));
    tbl.push_back(nv('0, 0, 0, 0));
    tbl.push_back(cv(2, 1, 'h30, 0, 1, 0, 0, 0));
    tbl.push_back(ipc(av(b(2), 2, 0, 0, 0), b(2)));
    tbl.push_back(nv('0, 0, 2, 'h30));
    tbl.push_back(nv('0, 1, 2, 'h30));
    tbl.push_back(nv(p4, 1, 2, 'h30));
    tbl.push_back(ipc(nv(p4, 1, 2, 'h30), b(2) | p4));
    x = nv(p4, 0, 0, 0); x.rst = 1; tbl.push_back(ipc(x, '0));
    tbl.push_back(ipc(nv('0, 0, 0, 0), '0));

    for (int k = 0; k < tbl.size(); k++)
      apply(tbl[k]);

    cur = '0;
    for (int k = 0; k < 1500; k++) begin
      x = nv('0, 0, 0, 0);
      x.chk = 0;
      cur = cur ^ N'($urandom & $urandom & $urandom);
      x.irq = cur;
      x.rst = ($urandom_range(0, 199) == 0);
      x.we  = ($urandom_range(0, 3) == 0);
      x.cid = IW'($urandom_range(0, 31));
      x.ie  = ($urandom_range(0, 3) != 0);
      x.lvl = 8'($urandom_range(0, 4) * 32);
      x.shv = 1'($urandom_range(0, 1));
      x.edg = 1'($urandom_range(0, 1));
      x.ack = ($urandom_range(0, 5) == 0);
      x.aid = $urandom_range(0, 1) ? IW'(m_s2id) : IW'($urandom_range(0, N-1));
      apply(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/cv32e41s_clic_arbiter.md
Name: cv32e41s_clic_arbiter

Overview:
- External CLIC arbiter that feeds the core's CLIC interrupt port (clic_irq/id/level/priv/shv).
- Latches NUM_IRQ raw interrupt lines as per-source pending bits, qualified by per-source enable and configuration.
- Selects the single highest-level enabled pending source and presents it to the core through a registered, pipelined path.
- Clears edge-triggered pending state on the core's take acknowledge. Sits between platform interrupt sources and the core.

Parameters:
- NUM_IRQ, 32, number of interrupt sources (2..1024).
- CLIC_ID_WIDTH, 5, width of interrupt ID. Must equal $clog2(NUM_IRQ).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- irq_i  in  NUM_IRQ  raw interrupt lines, already synchronous to clk
- cfg_we_i  in  1  per-source configuration write strobe
- cfg_id_i  in  CLIC_ID_WIDTH  source selected by the write
- cfg_ie_i  in  1  interrupt enable
- cfg_level_i  in  8  interrupt level
- cfg_shv_i  in  1  selective hardware vectoring
- cfg_edge_i  in  1  trigger type: 1=rising edge, 0=level
- irq_ack_i  in  1  core has taken the presented interrupt
- irq_ack_id_i  in  CLIC_ID_WIDTH  ID of the taken interrupt
- clic_irq_o  out  1  interrupt presented
- clic_irq_id_o  out  CLIC_ID_WIDTH  presented ID
- clic_irq_level_o  out  8  presented level
- clic_irq_priv_o  out  2  always machine mode (2'b11)
- clic_irq_shv_o  out  1  presented shv
- ip_o  out  NUM_IRQ  pending vector, for a debug/CSR readback

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears ip, ie, level, shv, edge, irq_q, the stage-2 register and the ack-blank counter.
  - Output reset values: clic_irq_o=0, id=0, level=0, shv=0, ip_o=0. clic_irq_priv_o=2'b11 always.
  - Reset mid-operation drops all pending and in-flight state in the same edge.
- irq_q is irq_i registered every cycle.
- Pending update, per source i:
  - Level-triggered: ip[i] <= irq_i[i].
  - Edge-triggered: ip[i] set when irq_i[i] & ~irq_q[i].
  - Edge-triggered: ip[i] cleared when irq_ack_i && irq_ack_id_i==i.
  - Simultaneous set and clear: set wins.
- Config write:
  - At cycle t, updates ie/level/shv/edge of source cfg_id_i.
  - Writes with cfg_id_i >= NUM_IRQ are ignored.
  - A write that changes edge also clears ip of that source.
  - Write and ack on the same source in the same cycle: both apply.
- Stage 1 (combinational from registered state):
  - cand[i] = ip[i] & ie[i] & (level[i] != 0). Level-0 sources are never presented.
  - Max-select over cand: highest level wins; on equal level, higher ID wins.
  - Implement as a log2(NUM_IRQ)-deep comparator tree.
- Stage 2: registers {valid, id, level, shv} of the winner every cycle.
  - clic_irq_o = stage-2 valid & (blank_cnt==0).
  - With no candidate: valid=0, and id/level/shv go to 0.
- Latency:
  - Edge-source rising edge at cycle t: ip set at t+1, clic_irq_o at t+2 (irq_i to clic_irq_o is 2 cycles for any source).
  - Level-source deassertion removes it from the output 2 cycles after irq_i falls.
- Ack blanking:
  - irq_ack_i loads blank_cnt=2. It decrements to 0 and saturates.
  - While blank_cnt!=0, clic_irq_o=0. This stops the cleared interrupt being re-presented from stale pipeline state.
  - An ack during blanking reloads the counter to 2.
  - An ack ID that does not match the presented ID still clears that ID's edge pending bit.
- A higher-level source arriving while a lower one is presented replaces the outputs at the next stage-2 update; there is no hold.
- Outputs never glitch: all are flop outputs, except clic_irq_o, which is flop AND flop.

Decomposition:
- In cv32e41s_pkg:
  - clic_src_cfg_t struct {ie, shv, edge, level[7:0]}.
  - Constant CLIC_LEVEL_W=8.
  - PRIV_LVL_M, which is already present.
- Sub-module cv32e41s_clic_max_select: parameterised combinational comparator tree, (valid, id, level, shv) vectors in, winner out. It is reused for the stage-1 select.

Test Plan:
- Reset, then source 3 edge, ie=1, level=0x40; pulse irq_i[3] at t -> clic_irq_o=1, id=3, level=0x40 at t+2; ip_o[3]=1 until ack.
- Sources 5 and 9 pending, level 0x20 and 0x80 -> id=9. Set both to level 0x80 -> id=9. Set src5 to 0x90 -> id=5.
- Ack id=9 while presenting 9 (edge), src5 level 0x20 pending -> clic_irq_o=0 for 2 cycles, then id=5; ip_o[9]=0.
- Level-triggered src 7, level 0x10, irq_i[7] held high, acked -> re-presented after blanking. Drop irq_i[7] -> clic_irq_o=0 two cycles later.
- Source at level 0 or ie=0 pending -> clic_irq_o stays 0. cfg write with cfg_id_i=NUM_IRQ -> no state change.
- Rising edge on irq_i[2] and ack id=2 in the same cycle -> ip_o[2]=1. Assert rst with 4 sources pending -> all outputs 0 next cycle.
